md_iter: RTL and testbench

Iterative multiply/divide responder for the multicycle core.
- The controller issues a one-cycle start with an operation code and two operands, then stalls until done.
- md_iter owns the architectural HI/LO registers and computes results over WIDTH+2 cycles using radix-2 shift-add (multiply) or restoring shift-subtract (divide).
- Sits between the operand registers (rs/rt values) and the write-back mux that reads HI/LO.

---
 rtl/md_iter.sv | 171 +++++++++++++++++
 tb/tb_md_iter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_iter.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring shift-subtract divide, WIDTH+2 cycles per op.
module md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mdop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] accHi_q, accHi_d;
    logic [WIDTH-1:0] accLo_q, accLo_d;
    logic [WIDTH-1:0] magB_q, magB_d;
    logic             isDiv_q, isDiv_d;
    logic             signQ_q, signQ_d;
    logic             signR_q, signR_d;

    logic             signedOp;
    logic             isDivOp;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic             divGe;
    logic [WIDTH-1:0] divSub;
    logic [2*WIDTH-1:0] prodRaw;
    logic [2*WIDTH-1:0] prodFix;

    // accHi:accLo is the product (multiply) or remainder:dividend/quotient (divide).
    assign mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, magB_q} : {(WIDTH+1){1'b0}});
    assign divShift = {accHi_q, accLo_q[WIDTH-1]};
    assign divGe    = (divShift >= {1'b0, magB_q});
    assign divSub   = divShift[WIDTH-1:0] - magB_q;
    assign prodRaw  = {accHi_q, accLo_q};
    assign prodFix  = signQ_q ? -prodRaw : prodRaw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            accHi_q <= '0;
            accLo_q <= '0;
            magB_q  <= '0;
            isDiv_q <= 1'b0;
            signQ_q <= 1'b0;
            signR_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            accHi_q <= accHi_d;
            accLo_q <= accLo_d;
            magB_q  <= magB_d;
            isDiv_q <= isDiv_d;
            signQ_q <= signQ_d;
            signR_q <= signR_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        accHi_d  = accHi_q;
        accLo_d  = accLo_q;
        magB_d   = magB_q;
        isDiv_d  = isDiv_q;
        signQ_d  = signQ_q;
        signR_d  = signR_q;
        signedOp = (mdop == OP_MULT) || (mdop == OP_DIV);
        isDivOp  = (mdop == OP_DIV) || (mdop == OP_DIVU);

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (mdop)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            accHi_d = '0;
                            accLo_d = (signedOp && a[WIDTH-1]) ? -a : a;
                            magB_d  = (signedOp && b[WIDTH-1]) ? -b : b;
                            isDiv_d = isDivOp;
                            // A zero divisor must leave the all-ones quotient unnegated.
                            signQ_d = signedOp && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
                            signR_d = signedOp && isDivOp && a[WIDTH-1];
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        OP_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (isDiv_q) begin
                    accHi_d = divGe ? divSub : divShift[WIDTH-1:0];
                    accLo_d = {accLo_q[WIDTH-2:0], divGe};
                end else begin
                    accHi_d = mulSum[WIDTH:1];
                    accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (isDiv_q) begin
                    lo_d = signQ_q ? -accLo_q : accLo_q;
                    hi_d = signR_q ? -accHi_q : accHi_q;
                end else begin
                    hi_d = prodFix[2*WIDTH-1:WIDTH];
                    lo_d = prodFix[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_md_iter.sv
// Self-checking bench for md_iter: directed corner cases plus randomized ops
// compared against an arithmetic reference model of HI/LO.
module tb_md_iter;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   mdop;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] modelHi = '0;
    logic [W-1:0] modelLo = '0;

    md_iter #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .mdop (mdop),
        .a    (a),
        .b    (b),
        .hi   (hi),
        .lo   (lo),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model straight from the arithmetic definition of each op.
    task automatic modelExec(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        int sa;
        int sb;
        logic [63:0] p;
        sa = av;
        sb = bv;
        case (op)
            3'b001: begin
                p = longint'(sa) * longint'(sb);
                modelHi = p[63:32];
                modelLo = p[31:0];
            end
            3'b010: begin
                p = {32'b0, av} * {32'b0, bv};
                modelHi = p[63:32];
                modelLo = p[31:0];
            end
            3'b011: begin
                if (bv == 0) begin
                    modelLo = '1;
                    modelHi = av;
                end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                    modelLo = 32'h8000_0000;
                    modelHi = '0;
                end else begin
                    modelLo = sa / sb;
                    modelHi = sa % sb;
                end
            end
            3'b100: begin
                if (bv == 0) begin
                    modelLo = '1;
                    modelHi = av;
                end else begin
                    modelLo = av / bv;
                    modelHi = av % bv;
                end
            end
            3'b101: modelHi = av;
            3'b110: modelLo = av;
            default: ;
        endcase
    endtask

    // Issue one op and follow it to completion; optionally fire a stray start at E5.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input bit strayStart);
        int n;
        int busyErr;
        bit arith;
        logic [W-1:0] oldHi;
        logic [W-1:0] oldLo;
        arith = (op >= 3'b001 && op <= 3'b100);
        oldHi = modelHi;
        oldLo = modelLo;
        modelExec(op, av, bv);
        start = 1'b1;
        mdop  = op;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        mdop  = 3'($urandom_range(0, 7));
        n       = 0;
        busyErr = 0;
        if (!arith) checkOutput({tag, "_mtbusy"}, 64'(busy), 64'(0));
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) busyErr++;
            if (n == 16) begin
                checkOutput({tag, "_holdhi"}, 64'(hi), 64'(oldHi));
                checkOutput({tag, "_holdlo"}, 64'(lo), 64'(oldLo));
            end
            if (strayStart && n == 4) begin
                start = 1'b1;
                mdop  = 3'b101;
                a     = $urandom;
            end
            if (strayStart && n == 5) start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_latency"}, 64'(n), arith ? 64'(W + 1) : 64'(0));
        checkOutput({tag, "_hi"}, 64'(hi), 64'(modelHi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(modelLo));
        if (arith) checkOutput({tag, "_busyrun"}, 64'(busyErr), 64'(0));
        @(posedge clk);
        #1;
        checkOutput({tag, "_donepulse"}, 64'(done), 64'(0));
        checkOutput({tag, "_busyafter"}, 64'(busy), 64'(0));
    endtask

    task automatic watchIdle(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        checkOutput({tag, "_quiet"}, 64'(seen), 64'(0));
    endtask

    initial begin
        logic [2:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst   = 1'b1;
        start = 1'b0;
        mdop  = 3'b000;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_hi", 64'(hi), 64'(0));
        checkOutput("rst_lo", 64'(lo), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));

        start = 1'b1;
        mdop  = 3'b000;
        @(posedge clk);
        #1;
        mdop = 3'b111;
        @(posedge clk);
        #1;
        start = 1'b0;
        watchIdle("invalid_op", 40);
        checkOutput("invalid_hi", 64'(hi), 64'(0));

        applyStimulus("mthi", 3'b101, 32'hDEAD_BEEF, 32'h0, 1'b0);
        applyStimulus("mtlo", 3'b110, 32'h0BAD_F00D, 32'h0, 1'b0);
        applyStimulus("mult", 3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        applyStimulus("multu", 3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        applyStimulus("div", 3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        applyStimulus("divu", 3'b100, 32'h0000_0007, 32'h0000_0002, 1'b0);
        applyStimulus("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        applyStimulus("divu_zero", 3'b100, 32'h1234_5678, 32'h0, 1'b0);
        applyStimulus("div_zero", 3'b011, 32'h8765_4321, 32'h0, 1'b0);
        applyStimulus("mult_stray", 3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        watchIdle("stray_noqueue", 5);

        start = 1'b1;
        mdop  = 3'b001;
        a     = 32'h7FFF_0001;
        b     = 32'h0003_0005;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelHi = '0;
        modelLo = '0;
        checkOutput("midrst_hi", 64'(hi), 64'(0));
        checkOutput("midrst_lo", 64'(lo), 64'(0));
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        watchIdle("midrst", 40);
        applyStimulus("multu_5x6", 3'b010, 32'd5, 32'd6, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            applyStimulus($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
